// File: rtl/bus_pkg.sv
// Shared definitions for the system bus arbitration protocol.
// Imported by the master port and by the arbiter and slave ports.
//  - BUS_ADDR_WIDTH / BUS_DATA_WIDTH : default serial address / data widths
//  - MODE_READ / MODE_WRITE          : encoding of the mmode line
//  - IDLE .. DONE                    : master-port state encoding
//  - cnt_width()                     : width of a 0..N-1 bit counter for the larger field
package bus_pkg;

    localparam int unsigned BUS_ADDR_WIDTH = 12;
    localparam int unsigned BUS_DATA_WIDTH = 8;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ   = 3'd1;
    localparam logic [2:0] ADDR  = 3'd2;
    localparam logic [2:0] WDATA = 3'd3;
    localparam logic [2:0] RWAIT = 3'd4;
    localparam logic [2:0] RDATA = 3'd5;
    localparam logic [2:0] DONE  = 3'd6;

    typedef enum logic [2:0] {
        StIdle  = IDLE,
        StReq   = REQ,
        StAddr  = ADDR,
        StWdata = WDATA,
        StRwait = RWAIT,
        StRdata = RDATA,
        StDone  = DONE
    } bus_state_e;

    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/bus_shift_reg.sv
// Parameterised shift register used both as PISO (load + shift out) and SIPO (shift in).
// Shifts right: ser_i enters at the MSB, ser_o is the LSB, so both directions are LSB-first.
// Priority: clear > load > shift.
//  clk_i       clock, rising edge
//  rst_i       asynchronous active-high reset
//  clear_i     synchronous clear to zero
//  load_i      parallel load from par_i
//  shift_i     shift one position
//  ser_i       serial input (enters at MSB)
//  par_i       parallel load value
//  ser_o       serial output (current LSB)
//  par_o       current register contents
//  par_next_o  value the register takes at the next edge
module bus_shift_reg #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic             ser_i,
    input  logic [Width-1:0] par_i,
    output logic             ser_o,
    output logic [Width-1:0] par_o,
    output logic [Width-1:0] par_next_o
);

    logic [Width-1:0] data_q;
    logic [Width-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (clear_i) begin
            data_d = '0;
        end else if (load_i) begin
            data_d = par_i;
        end else if (shift_i) begin
            // Written without a slice so Width == 1 stays legal.
            data_d = (data_q >> 1) | (Width'(ser_i) << (Width - 1));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign ser_o      = data_q[0];
    assign par_o      = data_q;
    assign par_next_o = data_d;

endmodule

// File: rtl/bus_master_port.sv
// Master-side endpoint of the system bus arbitration protocol. Accepts one local read/write,
// requests the bus, serialises address (+ write data) LSB-first once granted, captures serial
// read data, then releases breq and pulses rsp_valid. Losing the grant mid-transfer restarts the
// whole transfer from address bit 0.
// Optional feature: define BUS_TIMEOUT_EN to abort reads that wait TIMEOUT cycles with no svalid
// (rsp_err=1); otherwise RWAIT waits indefinitely and rsp_err is always 0.
//  clk, rst                    clock / asynchronous active-high reset
//  req_valid/ready/write/addr/wdata   local request handshake
//  rsp_valid/rdata/err         one-cycle completion pulse, held read data, timeout flag
//  breq, bgrant                arbiter request / grant
//  mout, mvalid, mmode         serial address/write-data bit, its qualifier, transfer direction
//  srdata, svalid              serial read-data bit from slave and its qualifier
module bus_master_port
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = BUS_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = BUS_DATA_WIDTH,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  breq,
    input  logic                  bgrant,
    output logic                  mout,
    output logic                  mvalid,
    output logic                  mmode,
    input  logic                  srdata,
    input  logic                  svalid
);

    localparam int unsigned CW = cnt_width(ADDR_WIDTH, DATA_WIDTH);

    bus_state_e            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q, err_d;

    logic tx_load, tx_shift, tx_ser;
    logic rx_shift, rx_clear, rdata_load;
    logic timeout_hit;
    logic [DATA_WIDTH-1:0] rx_next;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] unused_tx_par, unused_tx_next;
    logic [DATA_WIDTH-1:0] unused_rx_par;
    logic unused_rx_ser;

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [TW-1:0] tmo_q;

    assign timeout_hit = (tmo_q == TW'(TIMEOUT - 1));

    // Counts consecutive RWAIT cycles; cleared whenever RWAIT is left.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
        end else if (state_q == StRwait && state_d == StRwait) begin
            tmo_q <= tmo_q + TW'(1);
        end else begin
            tmo_q <= '0;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tx_load    = 1'b0;
        tx_shift   = 1'b0;
        rx_shift   = 1'b0;
        rx_clear   = 1'b0;
        rdata_load = 1'b0;
        err_d      = 1'b0;
        unique case (state_q)
            StIdle: if (req_valid) state_d = StReq;
            StReq: begin
                if (bgrant) begin
                    state_d = StAddr;
                    tx_load = 1'b1;
                    cnt_d   = '0;
                end
            end
            StAddr, StWdata, StRwait, StRdata: begin
                if (!bgrant) begin
                    // Grant lost: drop everything and re-arbitrate with breq still high.
                    state_d  = StReq;
                    cnt_d    = '0;
                    rx_clear = 1'b1;
                end else if (state_q == StAddr) begin
                    tx_shift = 1'b1;
                    if (cnt_q == CW'(ADDR_WIDTH - 1)) begin
                        cnt_d   = '0;
                        state_d = (write_q == MODE_WRITE) ? StWdata : StRwait;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (state_q == StWdata) begin
                    tx_shift = 1'b1;
                    if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                        cnt_d   = '0;
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (svalid) begin
                    // First svalid in RWAIT already carries bit 0.
                    rx_shift = 1'b1;
                    if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                        cnt_d      = '0;
                        state_d    = StDone;
                        rdata_load = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                        state_d = StRdata;
                    end
                end else if (state_q == StRwait && timeout_hit) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            write_q <= MODE_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            if (state_q == StIdle && req_valid) begin
                write_q <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (rdata_load) rdata_q <= rx_next;
        end
    end

    // Reloaded from the held request on every grant so a restart begins at address bit 0.
    bus_shift_reg #(
        .Width(ADDR_WIDTH + DATA_WIDTH)
    ) u_tx_sr (
        .clk_i     (clk),
        .rst_i     (rst),
        .clear_i   (1'b0),
        .load_i    (tx_load),
        .shift_i   (tx_shift),
        .ser_i     (1'b0),
        .par_i     ({wdata_q, addr_q}),
        .ser_o     (tx_ser),
        .par_o     (unused_tx_par),
        .par_next_o(unused_tx_next)
    );

    bus_shift_reg #(
        .Width(DATA_WIDTH)
    ) u_rx_sr (
        .clk_i     (clk),
        .rst_i     (rst),
        .clear_i   (rx_clear),
        .load_i    (1'b0),
        .shift_i   (rx_shift),
        .ser_i     (srdata),
        .par_i     ('0),
        .ser_o     (unused_rx_ser),
        .par_o     (unused_rx_par),
        .par_next_o(rx_next)
    );

    assign req_ready = (state_q == StIdle);
    assign breq      = (state_q != StIdle) && (state_q != StDone);
    assign mvalid    = (state_q == StAddr) || (state_q == StWdata);
    assign mout      = mvalid & tx_ser;
    assign mmode     = write_q;
    assign rsp_valid = (state_q == StDone);
    assign rsp_err   = (state_q == StDone) & err_q;
    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_bus_master_port.sv
module tb_bus_master_port;

    localparam int AW = 12;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          breq, bgrant, mout, mvalid, mmode, srdata, svalid;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_rdata = '0;
    int            lat;

    always #5 clk = ~clk;

    bus_master_port dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .breq     (breq),
        .bgrant   (bgrant),
        .mout     (mout),
        .mvalid   (mvalid),
        .mmode    (mmode),
        .srdata   (srdata),
        .svalid   (svalid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_breq"}, breq, 0);
        chk({tag, "_mvalid"}, mvalid, 0);
        chk({tag, "_mout"}, mout, 0);
        chk({tag, "_mmode"}, mmode, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    endtask

    // One transaction with a reactive arbiter/slave. The expected serial stream is the address
    // bits then (for writes) data bits, LSB-first; only the attempt after the last grant loss counts.
    task automatic txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                       input int gdelay, input int drop_at, input logic [DW-1:0] sd,
                       input int gap, output int lat_o);
        logic        q_exp[$];
        logic        q_got[$];
        logic [31:0] pk_exp, pk_got;
        int          cyc, drop_left, sent, gapc;
        bit          dropped, done, slave_on;
        for (int i = 0; i < AW; i++) q_exp.push_back(addr[i]);
        if (wr) for (int i = 0; i < DW; i++) q_exp.push_back(wd[i]);
        lat_o = -1; drop_left = 0; dropped = 0; done = 0; sent = 0; gapc = gap; slave_on = 0;
        chk("accept_ready", req_ready, 1);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
        bgrant = (gdelay == 0); svalid = 1'b0;
        tick();
        cyc = 1;
        while (!done && cyc < 2000) begin
            if (rsp_valid) begin
                done = 1; lat_o = cyc;
                req_valid = 1'b0; svalid = 1'b0;
            end else begin
                chk("breq_busy", breq, 1);
                if (cyc <= gdelay + 1) chk("mvalid_pre_grant", mvalid, 0);
                if (cyc == gdelay + 2) chk("first_bit_after_grant", mvalid, 1);
                if (!dropped && drop_at >= 0 && q_got.size() == drop_at && mvalid) begin
                    dropped = 1; drop_left = 3; q_got.delete();
                end else if (drop_left > 0) begin
                    chk("mvalid_grant_lost", mvalid, 0);
                end else if (mvalid) begin
                    q_got.push_back(mout);
                    chk("mmode", mmode, wr);
                end
                bgrant = !(cyc <= gdelay || drop_left > 0);
                if (drop_left > 0) drop_left--;
                if (!wr && !slave_on && drop_left == 0 && q_got.size() == AW && !mvalid)
                    slave_on = 1;
                if (slave_on && sent < DW) begin
                    if (gapc == 0) begin
                        svalid = 1'b1; srdata = sd[sent]; sent++; gapc = gap;
                    end else begin
                        svalid = 1'b0; srdata = 1'($urandom); gapc--;
                    end
                end else begin
                    // Noise only where the port must ignore it.
                    svalid = mvalid ? 1'($urandom) : 1'b0;
                    srdata = 1'($urandom);
                end
                req_valid = 1'($urandom); req_write = 1'($urandom);
                req_addr = AW'($urandom); req_wdata = DW'($urandom);
                tick();
                cyc++;
            end
        end
        checks++;
        assert (done)
        else begin
            errors++;
            $error("FAIL rsp_wait: no rsp_valid within %0d cycles", cyc);
        end
        if (done) begin
            chk("breq_done", breq, 0);
            chk("mvalid_done", mvalid, 0);
            chk("rsp_err", rsp_err, 0);
            chk("rsp_rdata", rsp_rdata, wr ? exp_rdata : sd);
            chk("bit_count", q_got.size(), q_exp.size());
            pk_exp = '0; pk_got = '0;
            foreach (q_exp[i]) pk_exp[i] = q_exp[i];
            foreach (q_got[i]) pk_got[i] = q_got[i];
            chk("serial_bits", pk_got, pk_exp);
            if (!wr) exp_rdata = sd;
            tick();
            chk("single_rsp", rsp_valid, 0);
            chk("idle_ready", req_ready, 1);
        end
    endtask

    initial begin
        int cyc, seen, gd, gp;
        logic wr;
        logic [DW-1:0] wd, sd;
        logic [AW-1:0] ad;

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        bgrant = 1'b0; srdata = 1'b0; svalid = 1'b0;
        tick(); tick();
        chk_reset_outputs("rst_held");
        rst = 1'b0;
        tick();
        chk_reset_outputs("rst_released");

        // Directed write, bgrant tied high.
        txn(1'b1, 12'h5A3, 8'hC4, 0, -1, 8'h00, 0, lat);
        chk("wr_latency", lat, 2 + AW + DW);

        // Directed read with 2-cycle svalid gaps.
        txn(1'b0, 12'h012, 8'h00, 0, -1, 8'hA7, 2, lat);

        // Grant delayed 10 cycles.
        txn(1'b1, AW'($urandom), DW'($urandom), 10, -1, 8'h00, 0, lat);
        chk("wr_latency_delayed", lat, 2 + AW + DW + 10);

        // Grant lost after 5 address bits, write and read.
        txn(1'b1, AW'($urandom), DW'($urandom), 0, 5, 8'h00, 0, lat);
        txn(1'b0, AW'($urandom), 8'h00, 2, 5, DW'($urandom), 1, lat);

        // Randomised transactions.
        for (int n = 0; n < 8; n++) begin
            wr = 1'($urandom); ad = AW'($urandom); wd = DW'($urandom); sd = DW'($urandom);
            gd = $urandom_range(0, 3); gp = $urandom_range(0, 2);
            txn(wr, ad, wd, gd, -1, sd, gp, lat);
            if (wr) chk("rand_wr_latency", lat, 2 + AW + DW + gd);
        end

        // Reset asserted in the middle of write data.
        req_valid = 1'b1; req_write = 1'b1; req_addr = AW'($urandom); req_wdata = DW'($urandom);
        bgrant = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (14) tick();
        chk("pre_rst_wdata_mvalid", mvalid, 1);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("mid_rst");
        exp_rdata = '0;
        tick();
        rst = 1'b0;
        seen = 0;
        repeat (5) begin
            if (rsp_valid) seen++;
            tick();
        end
        chk("post_rst_no_rsp", seen, 0);
        txn(1'b1, AW'($urandom), DW'($urandom), 1, -1, 8'h00, 0, lat);
        chk("post_rst_wr_latency", lat, 2 + AW + DW + 1);

        // Read with a silent slave.
        chk("to_accept_ready", req_ready, 1);
        req_valid = 1'b1; req_write = 1'b0; req_addr = AW'($urandom); bgrant = 1'b1;
        svalid = 1'b0;
        tick();
        req_valid = 1'b0;
        cyc = 1; seen = 0;
`ifdef BUS_TIMEOUT_EN
        while (!rsp_valid && cyc < 1000) begin
            srdata = 1'($urandom);
            tick();
            cyc++;
        end
        chk("timeout_latency", cyc, 2 + AW + 255);
        chk("timeout_err", rsp_err, 1);
        chk("timeout_rdata_kept", rsp_rdata, exp_rdata);
        chk("timeout_breq", breq, 0);
        tick();
        chk("timeout_single_rsp", rsp_valid, 0);
        chk("timeout_err_clear", rsp_err, 0);
`else
        repeat (1000) begin
            if (rsp_valid) seen++;
            srdata = 1'($urandom);
            tick();
        end
        chk("no_timeout_rsp", seen, 0);
        chk("still_waiting_breq", breq, 1);
        chk("still_waiting_ready", req_ready, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("recover_ready", req_ready, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
